instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter N_BITS, default 32: data, PC and instruction width.
REQ-002 Parameter HALT_OPCODE, default 6'b111111: opcode field value (bits [31:26]) that ends the program.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-high.
REQ-005 i_start  input  1  debug command: enter continuous run.
REQ-006 i_step  input  1  debug command: advance one fetch while in step mode.
REQ-007 i_halt  input  1  stall request from hazard detection.
REQ-008 i_flush  input  1  redirect/flush request from hazard detection.
REQ-009 i_jump_direction  input  N_BITS  redirect target PC.
REQ-010 i_instruction  input  N_BITS  instruction memory read data for o_imem_addr, combinational.
REQ-011 o_imem_addr  output  N_BITS  current PC, byte address.
REQ-012 o_pc_plus4  output  N_BITS  PC+4, combinational, the fall-through PC for hazard detection.
REQ-013 o_IF_ID_instruction  output  N_BITS  registered instruction to decode.
REQ-014 o_IF_ID_pc_plus4  output  N_BITS  registered PC+4 of that instruction.
REQ-015 o_IF_ID_valid  output  1  IF/ID holds a real fetched instruction.
REQ-016 o_state  output  2  run state: IDLE=00, RUN=01, STEP=10, DONE=11.
REQ-017 o_program_end  output  1  high exactly while state is DONE.
REQ-018 o_cycle_count  output  N_BITS  count of advance-enabled cycles.

Function
REQ-019 The block SHALL define adv_en = (state==RUN) or (state==STEP and i_step); no register except state changes when adv_en is low.
REQ-020 With adv_en high and i_flush high, the block SHALL load PC<=i_jump_direction, IF/ID instruction<=0, IF/ID pc_plus4<=0, valid<=0, regardless of i_halt.
REQ-021 With adv_en high, i_flush low, i_halt high, the block SHALL hold PC and all IF/ID registers.
REQ-022 With adv_en high, i_flush low, i_halt low, the block SHALL load PC<=PC+4, IF/ID instruction<=i_instruction, IF/ID pc_plus4<=PC+4, valid<=1.
REQ-023 PC+4 SHALL wrap modulo 2^N_BITS (0xFFFFFFFC -> 0x00000000).
REQ-024 IDLE: i_start -> RUN; else i_step -> STEP; else stay; no fetch in the transition cycle; i_start wins when both are high.
REQ-025 STEP: i_start -> RUN next cycle; each cycle with i_step high performs exactly one advance per REQ-020..022.
REQ-026 RUN or STEP: an advance per REQ-022 with i_instruction[31:26]==HALT_OPCODE SHALL load that instruction into IF/ID and move to DONE next cycle.
REQ-027 A halt opcode discarded by flush or held by stall SHALL NOT cause DONE.
REQ-028 DONE is sticky until reset; i_start, i_step, i_halt and i_flush SHALL be ignored there, and PC and IF/ID SHALL be frozen.
REQ-029 o_cycle_count SHALL increment on every adv_en cycle, including stalled and flushed ones, and saturate at all-ones.

Reset
REQ-030 While i_reset is high, independent of i_clk: PC=0, IF/ID instruction=0, IF/ID pc_plus4=0, valid=0, state=IDLE, o_program_end=0, o_cycle_count=0.
REQ-031 Assertion mid-RUN SHALL abort immediately; after release the block SHALL wait in IDLE for i_start or i_step.

Verification
REQ-032 Reset, i_start for 1 cycle, non-halt memory -> o_imem_addr 0,4,8,12 on consecutive cycles after RUN entry; first IF/ID pc_plus4=4, valid=1.
REQ-033 RUN at PC=8, i_halt high 2 cycles -> PC stays 8 and IF/ID unchanged for 2 cycles, then PC=12; o_cycle_count still +1 per cycle.
REQ-034 RUN, i_flush and i_halt both high, i_jump_direction=0x40 -> next PC=0x40, IF/ID instruction=0, valid=0.
REQ-035 IDLE, i_step pulse, then three single-cycle i_step pulses spaced by 2 idle cycles -> state STEP, PC 0->4->8->12 only on pulse cycles, o_cycle_count=3.
REQ-036 RUN, 0xFC000000 at address 0x10 -> IF/ID instruction=0xFC000000, state=DONE, o_program_end=1, PC=0x14 frozen; later i_start has no effect.
REQ-037 i_reset asserted asynchronously mid-RUN at PC=0x20 -> all outputs at REQ-030 values before the next clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the
// debug run-control state machine (IDLE / RUN / STEP / DONE).
module instruction_fetch #(
    parameter int unsigned N_BITS      = 32,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_halt,
    input  logic              i_flush,
    input  logic [N_BITS-1:0] i_jump_direction,
    input  logic [N_BITS-1:0] i_instruction,
    output logic [N_BITS-1:0] o_imem_addr,
    output logic [N_BITS-1:0] o_pc_plus4,
    output logic [N_BITS-1:0] o_IF_ID_instruction,
    output logic [N_BITS-1:0] o_IF_ID_pc_plus4,
    output logic              o_IF_ID_valid,
    output logic [1:0]        o_state,
    output logic              o_program_end,
    output logic [N_BITS-1:0] o_cycle_count
);

    localparam int unsigned OPC_W = 6;
    localparam logic [N_BITS-1:0] PC_INC   = N_BITS'(4);
    localparam logic [N_BITS-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] pc_q, pc_d;
    logic [N_BITS-1:0] ifid_instr_q, ifid_instr_d;
    logic [N_BITS-1:0] ifid_pc4_q, ifid_pc4_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              prog_end_q, prog_end_d;
    logic [N_BITS-1:0] cycle_cnt_q, cycle_cnt_d;

    logic              adv_en;
    logic [N_BITS-1:0] pc_plus4;
    logic              is_halt_op;

    assign pc_plus4   = pc_q + PC_INC;
    assign is_halt_op = (i_instruction[N_BITS-1 -: OPC_W] == HALT_OPCODE);
    assign adv_en     = (state_q == ST_RUN) || ((state_q == ST_STEP) && i_step);

    // Next-state computation for run control, PC, IF/ID and cycle counter
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        cycle_cnt_d  = cycle_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start)     state_d = ST_RUN;
                else if (i_step) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (i_start) state_d = ST_RUN;
            end
            default: ;
        endcase

        if (adv_en) begin
            if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + N_BITS'(1);
            if (i_flush) begin
                pc_d         = i_jump_direction;
                ifid_instr_d = '0;
                ifid_pc4_d   = '0;
                ifid_valid_d = 1'b0;
            end else if (!i_halt) begin
                pc_d         = pc_plus4;
                ifid_instr_d = i_instruction;
                ifid_pc4_d   = pc_plus4;
                ifid_valid_d = 1'b1;
                // A halt opcode that actually enters IF/ID ends the program
                if (is_halt_op) state_d = ST_DONE;
            end
        end

        prog_end_d = (state_d == ST_DONE);
    end

    // State and pipeline registers, cleared asynchronously by reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            prog_end_q   <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            prog_end_q   <= prog_end_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign o_imem_addr         = pc_q;
    assign o_pc_plus4          = pc_plus4;
    assign o_IF_ID_instruction = ifid_instr_q;
    assign o_IF_ID_pc_plus4    = ifid_pc4_q;
    assign o_IF_ID_valid       = ifid_valid_q;
    assign o_state             = state_q;
    assign o_program_end       = prog_end_q;
    assign o_cycle_count       = cycle_cnt_q;

endmodule
